alu_operand_sequencer: RTL and testbench

- Upstream feeder for the 8-bit ALU.
- Assembles two operands and an operation word from a byte-wide input stream, using a three-byte frame.
- Presents the assembled operation to the ALU with a valid/ready issue handshake.
- On the accepting edge, captures the ALU's combinational result and flags into a result register.
- Gives the tile a repeatable, clocked path into the ALU in place of fixed-add operation.

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_result_reg.sv | 62 ++++++
 rtl/alu_operand_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU operand sequencer
// Purpose: state enum, ALUControl opcodes, op-byte field positions, flag bit
//          indices and a reserved-field helper used by the sequencer files.
// Ports:   none (package)
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_ISSUE = 2'd3
    } seq_state_e;

    // ALUControl opcodes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    // Op-byte layout: [7:5] ALUControl, [4:3] shiftdesp, [2:0] reserved
    localparam int OPB_CTL_MSB  = 7;
    localparam int OPB_CTL_LSB  = 5;
    localparam int OPB_SH_MSB   = 4;
    localparam int OPB_SH_LSB   = 3;
    localparam int OPB_RSVD_MSB = 2;

    // Packed flag vector {V,C,N,Z}
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    function automatic logic rsvd_nonzero(input logic [7:0] op_byte);
        return |op_byte[OPB_RSVD_MSB:0];
    endfunction

endpackage

// File: rtl/alu_result_reg.sv
// rtl/alu_result_reg.sv - result/flag capture register with issue counter
// Purpose: latches the ALU's combinational result and flags on an accepted
//          issue, pulses res_valid for one cycle and counts completed issues.
// Ports:   clk, rst (sync, active-high)
//          capture_en  in  1  issue accepted this edge
//          alu_result  in  8  combinational ALU result
//          alu_flags   in  4  combinational flags {V,C,N,Z}
//          res         out 8  captured result
//          flags       out 4  captured flags {V,C,N,Z}
//          res_valid   out 1  one-cycle pulse after each capture
//          op_count    out 8  completed issues, wraps 255 -> 0
module alu_result_reg
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture_en,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [7:0] res,
    output logic [3:0] flags,
    output logic       res_valid,
    output logic [7:0] op_count
);

    logic [7:0] res_q, res_d;
    logic [3:0] flags_q, flags_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        res_d       = res_q;
        flags_d     = flags_q;
        op_count_d  = op_count_q;
        res_valid_d = capture_en;
        if (capture_en) begin
            res_d      = alu_result;
            flags_d    = alu_flags;
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= 8'h00;
            flags_q     <= 4'h0;
            res_valid_q <= 1'b0;
            op_count_q  <= 8'h00;
        end else begin
            res_q       <= res_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign res       = res_q;
    assign flags     = flags_q;
    assign res_valid = res_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - byte-stream to ALU operation sequencer
// Purpose: assembles {op_a, op_b, op byte} frames from a byte stream, issues
//          the operation to the ALU with valid/ready and captures the result.
// Ports:   clk, rst (sync, active-high)
//          data_in/data_valid/in_ready             byte input stream
//          op_a, op_b, alu_control, shiftdesp      operation to the ALU
//          issue_valid/issue_ready                 issue handshake
//          alu_result, alu_zero/negative/carry/overflow  ALU combinational outputs
//          res, flags, res_valid                   captured result {V,C,N,Z}
//          frame_err                               pulse on rejected op byte
//          op_count                                completed issues, wraps
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter bit CHECK_RSVD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       in_ready,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [2:0] alu_control,
    output logic [1:0] shiftdesp,
    output logic       issue_valid,
    input  logic       issue_ready,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    output logic [7:0] res,
    output logic [3:0] flags,
    output logic       res_valid,
    output logic       frame_err,
    output logic [7:0] op_count
);

    seq_state_e state_q, state_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic [2:0] alu_control_q, alu_control_d;
    logic [1:0] shiftdesp_q, shiftdesp_d;
    logic       issue_valid_q, issue_valid_d;
    logic       frame_err_q, frame_err_d;

    logic       accept;
    logic       capture;
    logic [3:0] alu_flags;

    // in_ready is the only combinational output; it drops during reset so
    // no byte is ever counted as consumed on a reset edge.
    assign in_ready = (state_q != S_ISSUE) && !rst;
    assign accept   = data_valid && in_ready;
    assign capture  = issue_valid_q && issue_ready;

    always_comb begin
        alu_flags        = 4'h0;
        alu_flags[FLG_Z] = alu_zero;
        alu_flags[FLG_N] = alu_negative;
        alu_flags[FLG_C] = alu_carry;
        alu_flags[FLG_V] = alu_overflow;
    end

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        alu_control_d = alu_control_q;
        shiftdesp_d   = shiftdesp_q;
        frame_err_d   = 1'b0;
        case (state_q)
            S_A: begin
                if (accept) begin
                    op_a_d  = data_in;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (accept) begin
                    op_b_d  = data_in;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (accept) begin
                    if (CHECK_RSVD && rsvd_nonzero(data_in)) begin
                        // Bad op byte: drop the whole frame, keep last opcode.
                        frame_err_d = 1'b1;
                        state_d     = S_A;
                    end else begin
                        alu_control_d = data_in[OPB_CTL_MSB:OPB_CTL_LSB];
                        shiftdesp_d   = data_in[OPB_SH_MSB:OPB_SH_LSB];
                        state_d       = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (capture) begin
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
        // Registered view of "next state is S_ISSUE" keeps issue_valid glitch-free.
        issue_valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_A;
            op_a_q        <= 8'h00;
            op_b_q        <= 8'h00;
            alu_control_q <= ALU_ADD;
            shiftdesp_q   <= 2'b00;
            issue_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            alu_control_q <= alu_control_d;
            shiftdesp_q   <= shiftdesp_d;
            issue_valid_q <= issue_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign alu_control = alu_control_q;
    assign shiftdesp   = shiftdesp_q;
    assign issue_valid = issue_valid_q;
    assign frame_err   = frame_err_q;

    alu_result_reg u_result_reg (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .res        (res),
        .flags      (flags),
        .res_valid  (res_valid),
        .op_count   (op_count)
    );

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] alu_control;
    logic [1:0] shiftdesp;
    logic       issue_valid;
    logic       issue_ready;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_negative;
    logic       alu_carry;
    logic       alu_overflow;
    logic [7:0] res;
    logic [3:0] flags;
    logic       res_valid;
    logic       frame_err;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.CHECK_RSVD(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_control  (alu_control),
        .shiftdesp    (shiftdesp),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .res          (res),
        .flags        (flags),
        .res_valid    (res_valid),
        .frame_err    (frame_err),
        .op_count     (op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is "bytes collected so far" plus one
    // pending operation; nothing is taken while an operation is pending.
    bit         chk_en    = 1'b0;
    bit         m_pending = 1'b0;
    int         m_nbytes  = 0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_res = 8'h00, m_cnt = 8'h00;
    logic [2:0] m_ctl = 3'b000;
    logic [1:0] m_sh  = 2'b00;
    logic [3:0] m_flags = 4'h0;
    logic       m_rv = 1'b0, m_fe = 1'b0;
    int         rv_seen = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_pending = 1'b0; m_nbytes = 0;
            m_a = 8'h00; m_b = 8'h00; m_res = 8'h00; m_cnt = 8'h00;
            m_ctl = 3'b000; m_sh = 2'b00; m_flags = 4'h0;
            m_rv = 1'b0; m_fe = 1'b0;
        end else begin
            m_rv = 1'b0;
            m_fe = 1'b0;
            if (m_pending) begin
                if (issue_ready) begin
                    m_res     = alu_result;
                    m_flags   = {alu_overflow, alu_carry, alu_negative, alu_zero};
                    m_cnt     = m_cnt + 8'd1;
                    m_rv      = 1'b1;
                    m_pending = 1'b0;
                end
            end else if (data_valid) begin
                m_nbytes++;
                if (m_nbytes == 1) m_a = data_in;
                else if (m_nbytes == 2) m_b = data_in;
                else begin
                    m_nbytes = 0;
                    if (data_in[2:0] != 3'b000) m_fe = 1'b1;
                    else begin
                        m_ctl     = data_in[7:5];
                        m_sh      = data_in[4:3];
                        m_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready",    32'(in_ready),    32'(!m_pending && !rst));
            check("issue_valid", 32'(issue_valid), 32'(m_pending));
            check("op_a",        32'(op_a),        32'(m_a));
            check("op_b",        32'(op_b),        32'(m_b));
            check("alu_control", 32'(alu_control), 32'(m_ctl));
            check("shiftdesp",   32'(shiftdesp),   32'(m_sh));
            check("res",         32'(res),         32'(m_res));
            check("flags",       32'(flags),       32'(m_flags));
            check("res_valid",   32'(res_valid),   32'(m_rv));
            check("frame_err",   32'(frame_err),   32'(m_fe));
            check("op_count",    32'(op_count),    32'(m_cnt));
            if (res_valid) rv_seen++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        cyc();
        data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; data_in = 8'h00; issue_ready = 1'b1;
        alu_result = 8'h00; alu_zero = 1'b0; alu_negative = 1'b0;
        alu_carry = 1'b0; alu_overflow = 1'b0;
        cyc();
        cyc();
        chk_en = 1'b1;
        check("rst_op_a", 32'(op_a), 32'h00);
        check("rst_op_count", 32'(op_count), 32'h00);
        check("rst_issue_valid", 32'(issue_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Add frame
        alu_result = 8'h08;
        send(8'h03); send(8'h05); send(8'h08);
        check("add_issue_valid", 32'(issue_valid), 32'h1);
        check("add_op_a", 32'(op_a), 32'h03);
        check("add_op_b", 32'(op_b), 32'h05);
        check("add_ctl", 32'(alu_control), 32'h0);
        check("add_sh", 32'(shiftdesp), 32'h1);
        check("add_in_ready", 32'(in_ready), 32'h0);
        cyc();
        check("add_res", 32'(res), 32'h08);
        check("add_flags", 32'(flags), 32'h0);
        check("add_res_valid", 32'(res_valid), 32'h1);
        check("add_op_count", 32'(op_count), 32'h01);
        check("add_issue_done", 32'(issue_valid), 32'h0);
        cyc();
        check("add_res_valid_pulse", 32'(res_valid), 32'h0);

        // Flag capture
        alu_result = 8'h80; alu_negative = 1'b1; alu_overflow = 1'b1;
        send(8'h7F); send(8'h01); send(8'h08);
        cyc();
        check("flg_res", 32'(res), 32'h80);
        check("flg_flags", 32'(flags), 32'b1010);
        check("flg_op_count", 32'(op_count), 32'h02);
        alu_negative = 1'b0; alu_overflow = 1'b0;

        // Backpressure with data_valid held during issue
        issue_ready = 1'b0;
        send(8'h10); send(8'h20); send(8'h48);
        data_valid = 1'b1; data_in = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("bp_issue_valid", 32'(issue_valid), 32'h1);
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_op_a", 32'(op_a), 32'h10);
            check("bp_op_b", 32'(op_b), 32'h20);
            check("bp_ctl", 32'(alu_control), 32'h2);
        end
        data_valid = 1'b0; issue_ready = 1'b1; alu_result = 8'h30;
        cyc();
        check("bp_res", 32'(res), 32'h30);
        check("bp_op_count", 32'(op_count), 32'h03);
        check("bp_res_valid", 32'(res_valid), 32'h1);

        // Reserved bits set in op byte
        send(8'h01); send(8'h02); send(8'h09);
        check("rsvd_frame_err", 32'(frame_err), 32'h1);
        check("rsvd_issue_valid", 32'(issue_valid), 32'h0);
        check("rsvd_ctl", 32'(alu_control), 32'h2);
        check("rsvd_sh", 32'(shiftdesp), 32'h1);
        send(8'h33);
        check("rsvd_next_op_a", 32'(op_a), 32'h33);
        check("rsvd_err_pulse", 32'(frame_err), 32'h0);
        send(8'h44); send(8'h20);
        check("rsvd_ctl_new", 32'(alu_control), 32'h1);
        cyc();
        check("rsvd_op_count", 32'(op_count), 32'h04);

        // Reset after the second byte
        send(8'h55); send(8'h66);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        cyc();
        rst = 1'b0;
        check("mid_rst_op_a", 32'(op_a), 32'h00);
        check("mid_rst_op_b", 32'(op_b), 32'h00);
        check("mid_rst_res", 32'(res), 32'h00);
        check("mid_rst_ctl", 32'(alu_control), 32'h0);
        check("mid_rst_op_count", 32'(op_count), 32'h00);
        alu_result = 8'h03;
        send(8'h01); send(8'h02); send(8'h00);
        check("clean_issue_valid", 32'(issue_valid), 32'h1);
        cyc();
        check("clean_res", 32'(res), 32'h03);
        check("clean_op_count", 32'(op_count), 32'h01);

        // Counter wrap over 256 back-to-back issues
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 256; i++) begin
            alu_result = 8'(i);
            send(8'(i)); send(8'(i + 1)); send(8'h00);
            cyc();
        end
        check("wrap_op_count", 32'(op_count), 32'h00);
        check("wrap_res", 32'(res), 32'hFF);
        cyc();
        check("wrap_res_valid_count", 32'(rv_seen), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
